step_accum8: RTL and testbench
==============================

// Module: step_accum8
// PURPOSE
//  Registered accumulator stage wrapped around the constant-operand 8-bit adder macro.
//  - Holds the running value and feeds it to the adder as operand A.
//  - Captures SUM/CO back into the accumulator and into a 1-entry output buffer.
//  - Presents the result downstream over a valid/ready handshake.
//  - Used as a step/address sequencer in the datapath; the adder stays purely combinational.
// PARAMETERS
//  WIDTH     8      datapath width; must match the adder macro width
//  STEP      8'd5   constant added per accepted step (operand B of the adder)
//  SAT_MODE  0      0 = wrap modulo 2^WIDTH; 1 = saturate at all-ones on carry
//  WCNT_W    4      width of the saturating wrap-event counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  load_i       in   1      synchronous load of accumulator from load_val_i
//  load_val_i   in   WIDTH  load value
//  step_i       in   1      step request (valid)
//  step_rdy_o   out  1      stage can accept a step this cycle
//  out_vld_o    out  1      output buffer holds a result
//  out_rdy_i    in   1      downstream accepts the result
//  out_val_o    out  WIDTH  buffered result
//  out_wrap_o   out  1      buffered result came from a carry (wrap or saturation)
//  acc_o        out  WIDTH  current accumulator value (operand A to the adder)
//  wrap_cnt_o   out  WCNT_W number of carry events since reset/load, saturating
// BEHAVIOUR
//  Reset (async, rst=1):
//  - acc_o=0, out_val_o=0, out_wrap_o=0, out_vld_o=0, wrap_cnt_o=0, FSM=EMPTY.
//  - step_rdy_o is 0 while rst=1, 1 from the first cycle after release.
//  FSM states:
//  - EMPTY: out_vld_o=0.
//  - FULL: out_vld_o=1.
//  - EMPTY->FULL on an accepted step; FULL->EMPTY when out_rdy_i=1 and no new step is accepted.
//  - FULL->FULL when out_rdy_i=1 and a step is accepted in the same cycle (back-to-back).
//  Readiness:
//  - step_rdy_o = !load_i && (state==EMPTY || out_rdy_i).
//  - Step accepted when step_i && step_rdy_o.
//  Arithmetic:
//  - {co,sum} = acc_o + STEP, zero-extended to WIDTH+1 bits.
//  - SAT_MODE=0: next acc = sum.
//  - SAT_MODE=1: next acc = co ? all-ones : sum.
//  - out_wrap_o = co.
//  - wrap_cnt_o increments on each accepted step with co=1; holds at 2^WCNT_W-1.
//  Latency:
//  - Accepted step at edge N: acc_o, out_val_o, out_wrap_o update at edge N; out_vld_o=1 after edge N.
//  - One result per cycle sustained while out_rdy_i=1.
//  Stall:
//  - While FULL and out_rdy_i=0: out_val_o/out_wrap_o stable; no step accepted; acc_o holds.
//  Load:
//  - Load has priority over step.
//  - On load_i: acc_o<=load_val_i, wrap_cnt_o<=0; step blocked that cycle.
//  - Output buffer unaffected by load: pending result stays valid until drained.
//  Boundaries:
//  - acc=all-ones minus (STEP-1) or higher produces co=1.
//  - SAT_MODE=1 at all-ones: every further step yields all-ones with out_wrap_o=1.
//  - Reset asserted mid-stall: discards the buffered result immediately.
//  - step_i asserted while step_rdy_o=0: ignored; no queuing.
// TESTING
//  1. Reset, out_rdy_i=1, step_i=1 for 3 cycles (STEP=5)
//     -> out_val_o 5,10,15 on consecutive cycles; out_vld_o stays 1; out_wrap_o=0.
//  2. load_val_i=8'hFD then one step
//     -> out_val_o=8'h02, out_wrap_o=1, wrap_cnt_o=1.
//     -> With SAT_MODE=1 instead: out_val_o=8'hFF, out_wrap_o=1.
//  3. out_rdy_i=0 after first result, step_i held high 4 cycles
//     -> out_val_o frozen at 5, step_rdy_o=0, acc_o=5.
//     -> out_rdy_i=1 then gives 10 on the next cycle.
//  4. load_i=1 and step_i=1 in the same cycle, load_val_i=8'h40
//     -> acc_o=8'h40, step not accepted, out_vld_o unchanged.
//  5. 20 steps from load 8'hFB with out_rdy_i=1
//     -> wrap_cnt_o saturates at 15 only after 15 carries.
//     -> A subsequent load clears wrap_cnt_o to 0.
//  6. Assert rst asynchronously mid-stall (FULL, out_rdy_i=0)
//     -> out_vld_o=0, acc_o=0 before the next clk edge.

Source files
------------

// File: rtl/step_accum8_if.sv
// Handshake and observation bundle for the step_accum8 accumulator stage.
// The master drives load/step/ready; the slave (the stage) returns the buffered result.
interface step_accum8_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WCNT_W = 4
);
  logic              load_i;
  logic [WIDTH-1:0]  load_val_i;
  logic              step_i;
  logic              step_rdy_o;
  logic              out_vld_o;
  logic              out_rdy_i;
  logic [WIDTH-1:0]  out_val_o;
  logic              out_wrap_o;
  logic [WIDTH-1:0]  acc_o;
  logic [WCNT_W-1:0] wrap_cnt_o;

  modport master (
    output load_i, load_val_i, step_i, out_rdy_i,
    input  step_rdy_o, out_vld_o, out_val_o, out_wrap_o, acc_o, wrap_cnt_o
  );

  modport slave (
    input  load_i, load_val_i, step_i, out_rdy_i,
    output step_rdy_o, out_vld_o, out_val_o, out_wrap_o, acc_o, wrap_cnt_o
  );
endinterface

// File: rtl/step_accum8.sv
// Registered accumulator around a constant-operand adder, with a one-entry
// valid/ready output buffer and a saturating carry-event counter.
module step_accum8 #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(5),
  parameter bit               SAT_MODE = 1'b0,
  parameter int unsigned      WCNT_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  step_accum8_if.slave bus
);

  localparam int unsigned       SUM_W    = WIDTH + 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  out_val_q;
  logic              out_wrap_q;
  logic [WCNT_W-1:0] wcnt_q;

  logic [SUM_W-1:0]  sum_ext;
  logic [WIDTH-1:0]  sum;
  logic              co;
  logic [WIDTH-1:0]  acc_nxt;
  logic              step_rdy;
  logic              step_acc;

  // Constant-operand adder: purely combinational, operand A is the accumulator.
  assign sum_ext = SUM_W'(acc_q) + SUM_W'(STEP);
  assign sum     = sum_ext[WIDTH-1:0];
  assign co      = sum_ext[WIDTH];
  assign acc_nxt = (SAT_MODE && co) ? {WIDTH{1'b1}} : sum;

  // Load wins over step; a full buffer only frees up when downstream takes it.
  assign step_rdy = !rst && !bus.load_i && ((state == EMPTY) || bus.out_rdy_i);
  assign step_acc = bus.step_i && step_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (step_acc) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (step_acc) begin
          state_nxt = FULL;
        end else if (bus.out_rdy_i) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Accumulator and output buffer; the buffer is untouched by a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      out_val_q  <= '0;
      out_wrap_q <= 1'b0;
    end else begin
      if (bus.load_i) begin
        acc_q <= bus.load_val_i;
      end else if (step_acc) begin
        acc_q <= acc_nxt;
      end
      if (step_acc) begin
        out_val_q  <= acc_nxt;
        out_wrap_q <= co;
      end
    end
  end

  // Carry events since reset or the last load, held at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else if (bus.load_i) begin
      wcnt_q <= '0;
    end else if (step_acc && co && (wcnt_q != WCNT_MAX)) begin
      wcnt_q <= wcnt_q + WCNT_W'(1);
    end
  end

  assign bus.step_rdy_o = step_rdy;
  assign bus.out_vld_o  = (state == FULL);
  assign bus.out_val_o  = out_val_q;
  assign bus.out_wrap_o = out_wrap_q;
  assign bus.acc_o      = acc_q;
  assign bus.wrap_cnt_o = wcnt_q;

endmodule

// File: tb/tb_step_accum8.sv
// Directed bench for step_accum8: one wrapping instance and one saturating instance
// on a shared clock and reset.
module tb_step_accum8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  step_accum8_if #(.WIDTH(8), .WCNT_W(4)) wif ();
  step_accum8_if #(.WIDTH(8), .WCNT_W(4)) sif ();

  step_accum8 #(.WIDTH(8), .STEP(8'd5), .SAT_MODE(1'b0), .WCNT_W(4)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wif.slave)
  );

  step_accum8 #(.WIDTH(8), .STEP(8'd5), .SAT_MODE(1'b1), .WCNT_W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned m_acc;
  int unsigned m_cnt;
  int unsigned m_sum;
  int unsigned m_co;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    wif.load_i = 1'b0; wif.load_val_i = 8'h00; wif.step_i = 1'b0; wif.out_rdy_i = 1'b0;
    sif.load_i = 1'b0; sif.load_val_i = 8'h00; sif.step_i = 1'b0; sif.out_rdy_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",      32'(wif.acc_o),      32'h00);
    check("rst_out_val",  32'(wif.out_val_o),  32'h00);
    check("rst_out_wrap", 32'(wif.out_wrap_o), 32'h0);
    check("rst_out_vld",  32'(wif.out_vld_o),  32'h0);
    check("rst_wcnt",     32'(wif.wrap_cnt_o), 32'h0);
    check("rst_step_rdy", 32'(wif.step_rdy_o), 32'h0);
    rst = 1'b0;
    tick();
    check("rel_step_rdy", 32'(wif.step_rdy_o), 32'h1);

    // Test 1: three back-to-back steps
    wif.out_rdy_i = 1'b1;
    wif.step_i    = 1'b1;
    tick();
    check("t1_val0",  32'(wif.out_val_o),  32'd5);
    check("t1_vld0",  32'(wif.out_vld_o),  32'h1);
    check("t1_wrap0", 32'(wif.out_wrap_o), 32'h0);
    tick();
    check("t1_val1",  32'(wif.out_val_o),  32'd10);
    check("t1_vld1",  32'(wif.out_vld_o),  32'h1);
    tick();
    check("t1_val2",  32'(wif.out_val_o),  32'd15);
    check("t1_vld2",  32'(wif.out_vld_o),  32'h1);
    check("t1_wrap2", 32'(wif.out_wrap_o), 32'h0);
    check("t1_acc2",  32'(wif.acc_o),      32'd15);
    wif.step_i = 1'b0;
    tick();
    check("t1_drain", 32'(wif.out_vld_o), 32'h0);

    // Test 3: stall with step held high, then release
    wif.load_i = 1'b1; wif.load_val_i = 8'h00;
    tick();
    wif.load_i = 1'b0;
    check("t3_load0", 32'(wif.acc_o), 32'h00);
    wif.out_rdy_i = 1'b0;
    wif.step_i    = 1'b1;
    tick();
    check("t3_first", 32'(wif.out_val_o), 32'd5);
    check("t3_fvld",  32'(wif.out_vld_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_stall_val", 32'(wif.out_val_o),  32'd5);
      check("t3_stall_rdy", 32'(wif.step_rdy_o), 32'h0);
      check("t3_stall_acc", 32'(wif.acc_o),      32'd5);
      check("t3_stall_vld", 32'(wif.out_vld_o),  32'h1);
    end
    wif.out_rdy_i = 1'b1;
    tick();
    check("t3_resume", 32'(wif.out_val_o), 32'd10);
    check("t3_racc",   32'(wif.acc_o),     32'd10);
    wif.step_i = 1'b0;
    tick();
    check("t3_noqueue_vld", 32'(wif.out_vld_o), 32'h0);
    check("t3_noqueue_acc", 32'(wif.acc_o),     32'd10);

    // Test 2: carry out of 0xFD, wrap mode
    wif.load_i = 1'b1; wif.load_val_i = 8'hFD;
    tick();
    wif.load_i = 1'b0;
    wif.step_i = 1'b1;
    tick();
    wif.step_i = 1'b0;
    check("t2_val",  32'(wif.out_val_o),  32'h02);
    check("t2_wrap", 32'(wif.out_wrap_o), 32'h1);
    check("t2_wcnt", 32'(wif.wrap_cnt_o), 32'h1);
    tick();

    // Test 2 (saturating instance)
    sif.out_rdy_i = 1'b1;
    sif.load_i = 1'b1; sif.load_val_i = 8'hFD;
    tick();
    sif.load_i = 1'b0;
    sif.step_i = 1'b1;
    tick();
    check("t2s_val",  32'(sif.out_val_o),  32'hFF);
    check("t2s_wrap", 32'(sif.out_wrap_o), 32'h1);
    check("t2s_acc",  32'(sif.acc_o),      32'hFF);
    tick();
    check("t2s_hold_val",  32'(sif.out_val_o),  32'hFF);
    check("t2s_hold_wrap", 32'(sif.out_wrap_o), 32'h1);
    check("t2s_hold_wcnt", 32'(sif.wrap_cnt_o), 32'h2);
    sif.step_i = 1'b0;
    tick();

    // Test 5: counter saturation on the saturating instance
    sif.load_i = 1'b1; sif.load_val_i = 8'hFB;
    tick();
    check("t5_load_wcnt", 32'(sif.wrap_cnt_o), 32'h0);
    sif.load_i = 1'b0;
    sif.step_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("t5_wcnt", 32'(sif.wrap_cnt_o), (k > 15) ? 32'd15 : 32'(k));
      check("t5_val",  32'(sif.out_val_o),  32'hFF);
    end
    sif.step_i = 1'b0;
    sif.load_i = 1'b1; sif.load_val_i = 8'h10;
    tick();
    sif.load_i = 1'b0;
    check("t5_clear", 32'(sif.wrap_cnt_o), 32'h0);
    check("t5_lacc",  32'(sif.acc_o),      32'h10);

    // Test 4a: load and step together while empty
    wif.out_rdy_i = 1'b1;
    wif.load_i = 1'b1; wif.load_val_i = 8'h40; wif.step_i = 1'b1;
    #1;
    check("t4a_rdy", 32'(wif.step_rdy_o), 32'h0);
    tick();
    check("t4a_acc",  32'(wif.acc_o),      32'h40);
    check("t4a_vld",  32'(wif.out_vld_o),  32'h0);
    check("t4a_wcnt", 32'(wif.wrap_cnt_o), 32'h0);

    // Test 4b: load during a stall keeps the pending result
    wif.load_i = 1'b0; wif.out_rdy_i = 1'b0;
    tick();
    check("t4b_val", 32'(wif.out_val_o), 32'h45);
    wif.load_i = 1'b1; wif.load_val_i = 8'h40;
    tick();
    check("t4b_acc", 32'(wif.acc_o),     32'h40);
    check("t4b_val2", 32'(wif.out_val_o), 32'h45);
    check("t4b_vld", 32'(wif.out_vld_o), 32'h1);
    wif.load_i = 1'b0; wif.step_i = 1'b0; wif.out_rdy_i = 1'b1;
    tick();
    check("t4b_drain", 32'(wif.out_vld_o), 32'h0);

    // Long wrap-mode run against a reference sequence
    wif.load_i = 1'b1; wif.load_val_i = 8'hFB;
    tick();
    wif.load_i = 1'b0;
    wif.step_i = 1'b1;
    m_acc = 32'hFB;
    m_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      m_sum = m_acc + 5;
      m_co  = (m_sum > 255) ? 1 : 0;
      m_acc = m_sum % 256;
      if (m_co == 1 && m_cnt < 15) m_cnt++;
      tick();
      check("run_val",  32'(wif.out_val_o),  m_acc);
      check("run_wrap", 32'(wif.out_wrap_o), m_co);
      check("run_wcnt", 32'(wif.wrap_cnt_o), m_cnt);
    end
    wif.step_i = 1'b0;
    tick();

    // Test 6: asynchronous reset in the middle of a stall
    wif.out_rdy_i = 1'b0;
    wif.step_i    = 1'b1;
    tick();
    wif.step_i = 1'b0;
    check("t6_full", 32'(wif.out_vld_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_vld",  32'(wif.out_vld_o),  32'h0);
    check("t6_acc",  32'(wif.acc_o),      32'h00);
    check("t6_val",  32'(wif.out_val_o),  32'h00);
    check("t6_rdy",  32'(wif.step_rdy_o), 32'h0);
    #2;
    rst = 1'b0;
    tick();
    check("t6_rel_rdy", 32'(wif.step_rdy_o), 32'h1);
    check("t6_rel_vld", 32'(wif.out_vld_o),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
